// File: rtl/tff_pkg.sv
// Shared types and constants for the toggle-flop counter controller.
package tff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: falling-edge clock, asynchronous preset and clear.
module tff_cell (
    input  logic clk,
    input  logic t,
    input  logic pre,
    input  logic clr,
    output logic q
);

    // Preset dominates clear when both are asserted.
    always_ff @(negedge clk or posedge pre or posedge clr) begin
        if (pre) begin
            q <= 1'b1;
        end else if (clr) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer for a bank of WIDTH toggle cells forming a loadable up/down counter.
// Optional periodic reload at terminal count: define TFF_CTRL_AUTORELOAD_EN.
module tff_count_ctrl
    import tff_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_t           state, state_nxt;
    logic             mode_q;
    logic [WIDTH-1:0] pre_q, clr_q, cell_clr;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] term_val;
    logic             carry;
    logic             load_now;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tc) begin
`ifdef TFF_CTRL_AUTORELOAD_EN
                    state_nxt = RUN;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TFF_CTRL_AUTORELOAD_EN
    logic done_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == RUN) && tc && !stop;
        end
    end
`endif

    always_comb begin
        busy = (state == RUN);
`ifdef TFF_CTRL_AUTORELOAD_EN
        done = done_q;
`else
        done = (state == DONE);
`endif
    end

    assign load_now = (state == IDLE) && cfg_load && !start;

    // Load strobes are registered so the preset lands just after the sampling
    // edge and the async cell inputs come glitch-free from flops.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_DOWN;
            pre_q  <= '0;
            clr_q  <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                mode_q <= mode;
            end
            pre_q <= load_now ? load_val  : '0;
            clr_q <= load_now ? ~load_val : '0;
        end
    end

    assign cell_clr = clr_q | {WIDTH{rst}};

    always_comb begin
        term_val = (mode_q == MODE_UP) ? '1 : '0;
        tc       = (state == RUN) && (count == term_val);
    end

    // Ripple enable: a cell toggles when every lower cell sits at the carry
    // (up) or borrow (down) value, so the bank steps by exactly one.
    always_comb begin
        t     = '0;
        carry = 1'b1;
        if ((state == RUN) && !stop) begin
            if (!tc) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    t[i]  = carry;
                    carry = carry & ((mode_q == MODE_UP) ? count[i] : ~count[i]);
                end
            end
`ifdef TFF_CTRL_AUTORELOAD_EN
            // Reload through the toggle path: flipping exactly the differing
            // bits lands load_val on this edge without touching pre/clr.
            else begin
                t = count ^ load_val;
            end
`endif
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .t   (t[i]),
            .pre (pre_q[i]),
            .clr (cell_clr[i]),
            .q   (count[i])
        );
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomized and directed bench for tff_count_ctrl against an arithmetic reference model.
module tb_tff_count_ctrl;

    localparam int unsigned W    = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_load;
    logic [W-1:0] load_val;
    logic         mode;
    logic         start;
    logic         stop;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         tc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    int unsigned m_count;
    bit          m_run;
    bit          m_dcyc;
    bit          m_pulse;
    bit          m_mode;

    always #5 clk = ~clk;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_load (cfg_load),
        .load_val (load_val),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .tc       (tc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int unsigned m_term();
        return m_mode ? MASK : 0;
    endfunction

    task automatic model_reset();
        m_count = 0; m_run = 0; m_dcyc = 0; m_pulse = 0; m_mode = 0;
    endtask

    // One active edge of the reference: idle / running / completion-cycle.
    task automatic model_step();
        m_pulse = 0;
        if (m_dcyc) begin
            m_dcyc = 0;
        end else if (m_run) begin
            if (stop) begin
                m_run = 0;
            end else if (m_count == m_term()) begin
`ifdef TFF_CTRL_AUTORELOAD_EN
                m_count = load_val;
                m_pulse = 1;
`else
                m_run  = 0;
                m_dcyc = 1;
`endif
            end else begin
                m_count = m_mode ? ((m_count + 1) & MASK) : ((m_count - 1) & MASK);
            end
        end else if (start) begin
            m_run  = 1;
            m_mode = mode;
        end else if (cfg_load) begin
            m_count = load_val;
        end
    endtask

    task automatic compare_all();
        check("count", count, m_count);
        check("busy",  busy,  m_run);
        check("done",  done,  m_dcyc | m_pulse);
        check("tc",    tc,    m_run && (m_count == m_term()));
        if (done === 1'b1) n_done++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        cfg_load = 0; start = 0; stop = 0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load_val = v; cfg_load = 1;
        tick();
        cfg_load = 0;
    endtask

    task automatic do_start(input logic m);
        mode = m; start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        rst = 1; idle_inputs(); load_val = '0; mode = 0;
        model_reset();
        #1;
        check("rst_count", count, 0);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_tc",    tc,    0);
        @(negedge clk); #2 rst = 0;
        @(posedge clk); compare_all();

        // Down count from 5: done once on the 6th edge after start.
        do_load(8'd5);
        do_start(1'b0);
        n_done = 0;
        repeat (7) tick();
        check("down5_done_once", n_done, 1);

        // Up count from 0xFC, count holds all ones afterwards.
        do_load(8'hFC);
        do_start(1'b1);
        repeat (5) tick();
        check("up_hold_ff", count, 8'hFF);

        // Stop at 7 freezes the count, a new start resumes from it.
        do_load(8'd10);
        do_start(1'b0);
        for (int g = 0; g < 20 && m_count != 7; g++) tick();
        stop = 1; tick(); stop = 0;
        check("stop_count", count, 7);
        check("stop_busy",  busy,  0);
        repeat (2) tick();
        do_start(1'b0);
        repeat (3) tick();
        check("resume_count", count, 4);
        repeat (6) tick();

        // start beats cfg_load; cfg_load is ignored while running.
        do_load(8'd9);
        load_val = 8'd3; cfg_load = 1; mode = 0; start = 1;
        tick();
        idle_inputs();
        tick();
        check("start_wins", count, 8);
        load_val = 8'd3; cfg_load = 1;
        repeat (2) tick();
        cfg_load = 0;
        check("load_in_run", count, 6);
        repeat (10) tick();

        // Asynchronous reset mid-run, between clock edges.
        do_load(8'd20);
        do_start(1'b0);
        repeat (3) tick();
        #2 rst = 1;
        #1;
        model_reset();
        check("arst_count", count, 0);
        check("arst_busy",  busy,  0);
        check("arst_done",  done,  0);
        @(negedge clk); #2 rst = 0;
        @(posedge clk); compare_all();

`ifdef TFF_CTRL_AUTORELOAD_EN
        do_load(8'd2);
        do_start(1'b0);
        n_done = 0;
        repeat (9) tick();
        check("reload_dones", n_done, 3);
        stop = 1; tick(); stop = 0;
        check("reload_stop_busy", busy, 0);
`endif

        // Randomized traffic against the model.
        repeat (600) begin
            cfg_load = ($urandom % 6) == 0;
            start    = ($urandom % 8) == 0;
            stop     = ($urandom % 24) == 0;
            mode     = $urandom % 2;
            load_val = W'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
